led_fade_pwm: RTL
=================

Name: led_fade_pwm

Overview:
- Downstream stage of the LED blinker pattern generator. Consumes its 8 LED pattern bits and drives the board LED pins.
- Each LED ramps brightness up or down via PWM instead of switching hard on/off.
- The pattern generator runs on a slow divided clock, so led_in is synchronized into clk here.
- fade_en=0 gives a plain registered pass-through.

Parameters:
PWM_BITS, 8, width of PWM counter and per-LED brightness level; MAX = 2^PWM_BITS-1
PRE_BITS, 16, width of fade-step prescaler counter
FADE_DIV, 16'd46875, clk cycles per fade step (1..2^PRE_BITS-1)
STEP, 8'd4, brightness increment/decrement per fade step (1..MAX)

Ports:
clk  input  1  system clock (12 MHz board clock)
NOTRESET  input  1  asynchronous, active-high reset
led_in  input  8  LED pattern from blinker stage, asynchronous to clk
fade_en  input  1  1 = fade mode, 0 = bypass; quasi-static, sampled on clk
led_out  output  8  PWM-driven LED pins, registered

Behaviour:
- Reset: NOTRESET, asynchronous, active-high; clock clk, rising edge.
- While NOTRESET=1, the following are all 0: sync stages, prescaler, pwm_cnt, all level[i], fade_tick, led_out. The first update occurs on the first clk edge after NOTRESET deasserts.
- Input sync: led_in passes through two flops per bit (s1, s2); s2 is led_sync. A change on led_in is visible in led_sync after 2 clk edges. No other logic uses raw led_in.
- Prescaler: increments every clk.
  - At FADE_DIV-1 it wraps to 0 and fade_tick=1 for exactly that one cycle.
  - FADE_DIV=1 gives fade_tick every cycle.
- pwm_cnt: free-running PWM_BITS counter. Increments every clk and wraps MAX->0. Period = 2^PWM_BITS clk.
- Level update, fade mode (fade_en=1), per LED i, only on cycles with fade_tick=1:
  - led_sync[i]=1: level <= min(level+STEP, MAX). Compute the sum PWM_BITS+1 wide, then saturate; no wrap.
  - led_sync[i]=0: level <= max(level-STEP, 0). Saturate at 0; no underflow.
  - Between ticks, level holds.
- Output, fade mode: led_out[i] <= (level[i]==MAX) ? 1 : (level[i] > pwm_cnt).
  - level 0: always off.
  - level MAX: solid on.
  - Otherwise: duty = level/2^PWM_BITS.
- Bypass (fade_en=0):
  - Every clk: level[i] <= led_sync[i] ? MAX : 0, and led_out[i] <= led_sync[i].
  - Latency led_in -> led_out is 3 clk edges.
  - fade_tick is ignored, but the prescaler keeps counting.
- Mode switch: bypass->fade resumes ramping from level=MAX/0, so there is no glitch. Fade->bypass snaps led_out to led_sync on the next edge.
- Simultaneous events: a led_sync toggle coincident with fade_tick takes effect at that tick, using the new led_sync value.
- Reset mid-ramp clears levels immediately. After release, LEDs ramp up from 0; there is no memory of the prior level.
- Full ramp time 0->MAX = ceil(MAX/STEP) fade ticks. Defaults: 64 ticks x 3.9 ms ~= 250 ms.

Decomposition:
- Package led_fade_pkg: NUM_LEDS=8 and the default PWM_BITS/PRE_BITS/FADE_DIV/STEP constants.
- Sub-module led_fade_chan, instantiated NUM_LEDS times:
  - inputs: clk, NOTRESET, led_sync bit, fade_tick, fade_en, pwm_cnt;
  - holds level and the saturating up/down logic;
  - outputs the registered led_out bit.
- Top keeps the synchronizer, prescaler and pwm_cnt.

Test Plan:
All tests use PWM_BITS=4, PRE_BITS=4, FADE_DIV=4, STEP=3 (MAX=15).
1. Reset: hold NOTRESET=1 and toggle led_in=8'hFF -> led_out=0, levels=0. Release -> first fade_tick 4 clk later. Also assert NOTRESET asynchronously between clk edges mid-ramp -> led_out=0 before the next edge.
2. Ramp-up saturation: fade_en=1, led_in[0]=1 -> level[0] goes 3,6,9,12,15 on successive ticks and stays 15 (no wrap to 2). At level 6, led_out[0] is high exactly 6 of every 16 clk. At level 15, it is solid high.
3. Ramp-down floor: from level 15, led_in[0]=0 -> 12,9,6,3,0, then stays 0 (no wrap to 13). led_out[0] is constant 0 at level 0.
4. Bypass latency: fade_en=0, led_in 8'h00->8'hA5 -> led_out=8'hA5 exactly on the 3rd clk edge. Switch fade_en=1 with led_in=8'h00 -> bits 0,2,5,7 step down from 15 to 12 at the next tick.
5. Coincidence: led_in[3] toggles 1->0 so that led_sync changes on a fade_tick cycle at level 9 -> level 6 at that tick, not 12.
6. Independence: led_in=8'h0F steady for 6 ticks -> levels[3:0]=15, levels[7:4]=0, led_out=8'h0F solid.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared constants for the LED fade/PWM output stage.
// The defaults target the 12 MHz board clock: one fade step every 46875 clk
// (~3.9 ms) and 64 steps from dark to full brightness.
package led_fade_pkg;

  localparam int NUM_LEDS     = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int PRE_BITS_DEF = 16;
  localparam int FADE_DIV_DEF = 46875;
  localparam int STEP_DEF     = 4;

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pin bundle between the blinker pattern stage and the LED fade/PWM stage.
// There is no valid/ready handshake on this bundle: led_in is a level that is
// continuously sampled (through a synchronizer), fade_en is a quasi-static
// mode select, and led_out is a registered level driven every clk. The
// level_dbg and fade_tick_dbg signals expose internal state for checkers.
interface led_fade_pwm_if
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
);

  logic [NUM_LEDS-1:0]          led_in;
  logic                         fade_en;
  logic [NUM_LEDS-1:0]          led_out;
  // LED i occupies bits [i*PWM_BITS +: PWM_BITS]
  logic [NUM_LEDS*PWM_BITS-1:0] level_dbg;
  logic                         fade_tick_dbg;

  modport master (
    output led_in,
    output fade_en,
    input  led_out,
    input  level_dbg,
    input  fade_tick_dbg
  );

  modport slave (
    input  led_in,
    input  fade_en,
    output led_out,
    output level_dbg,
    output fade_tick_dbg
  );

endinterface

// File: rtl/led_fade_chan.sv
// One LED channel: holds the brightness level, steps it up or down with
// saturation on each fade tick, and compares it against the shared PWM
// counter to produce the registered LED pin value.
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic                clk,
  input  logic                NOTRESET,
  input  logic                led_sync_i,
  input  logic                fade_tick_i,
  input  logic                fade_en_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [PWM_BITS-1:0] level_o,
  output logic                led_o
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  logic [PWM_BITS:0]   sum_up;
  logic [PWM_BITS-1:0] lvl_up, lvl_down;

  // Next level and next pin value; bypass tracks the input directly, fade
  // mode only moves the level on tick cycles.
  always_comb begin
    level_d  = level_q;
    led_d    = led_q;
    // One extra bit catches the carry so the ramp saturates instead of wrapping.
    sum_up   = {1'b0, level_q} + {1'b0, STEP_V};
    lvl_up   = sum_up[PWM_BITS] ? MAX : sum_up[PWM_BITS-1:0];
    lvl_down = (level_q < STEP_V) ? '0 : (level_q - STEP_V);

    if (!fade_en_i) begin
      // Park the level at a rail so a later switch to fade mode ramps
      // smoothly from where the LED visibly is.
      level_d = led_sync_i ? MAX : '0;
      led_d   = led_sync_i;
    end else begin
      if (fade_tick_i) begin
        level_d = led_sync_i ? lvl_up : lvl_down;
      end
      // MAX is forced solid: level > pwm_cnt alone would leave one dark
      // slot per PWM period.
      led_d = (level_q == MAX) || (level_q > pwm_cnt_i);
    end
  end

  // Level and pin registers, cleared asynchronously.
  always_ff @(posedge clk or posedge NOTRESET) begin
    if (NOTRESET) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign level_o = level_q;
  assign led_o   = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade/PWM output stage. Synchronizes the slow-clock pattern bits into
// clk, generates the fade-step tick and the shared PWM ramp, and instantiates
// one fade channel per LED.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRE_BITS = PRE_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic           clk,
  input  logic           NOTRESET,
  led_fade_pwm_if.slave  bus
);

  localparam logic [PRE_BITS-1:0] DIV_LAST = PRE_BITS'(FADE_DIV - 1);

  logic [NUM_LEDS-1:0] s1_q, s2_q;
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  logic [NUM_LEDS-1:0]               led_w;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] lvl_w;

  // Two-flop synchronizer; led_in comes from the divided blinker clock.
  always_ff @(posedge clk or posedge NOTRESET) begin
    if (NOTRESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.led_in;
      s2_q <= s1_q;
    end
  end

  // Prescaler wrap, tick and PWM ramp next-state.
  always_comb begin
    pre_d  = (pre_q == DIV_LAST) ? '0 : (pre_q + PRE_BITS'(1));
    tick_d = (pre_q == DIV_LAST);
    pwm_d  = pwm_q + PWM_BITS'(1);
  end

  // Prescaler, registered one-cycle fade tick and free-running PWM counter.
  // The prescaler keeps counting in bypass so the tick phase never jumps.
  always_ff @(posedge clk or posedge NOTRESET) begin
    if (NOTRESET) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_chan (
      .clk         (clk),
      .NOTRESET    (NOTRESET),
      .led_sync_i  (s2_q[i]),
      .fade_tick_i (tick_q),
      .fade_en_i   (bus.fade_en),
      .pwm_cnt_i   (pwm_q),
      .level_o     (lvl_w[i]),
      .led_o       (led_w[i])
    );
  end

  assign bus.led_out       = led_w;
  assign bus.level_dbg     = lvl_w;
  assign bus.fade_tick_dbg = tick_q;

endmodule
